imem_loader: RTL and testbench

- Boot-time writer for the CPU instruction ROM/RAM. The fetch stage only ever reads this memory.
- Receives a framed byte stream over a valid/ready byte interface (fed by the UART RX or a debug bridge).
- Assembles the bytes into little-endian 32-bit words and writes them sequentially from word address 0.
- Holds the CPU (gates F_en and the core reset) until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The slave side is the loader: it consumes bytes and drives the write port.
// The master side is the environment: the byte source plus the memory/observer.
interface imem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Receives a framed byte stream
// (16-bit big-endian word count, 4*N little-endian data bytes, XOR checksum),
// writes the words from address 0 and releases the CPU only after the
// checksum matches. All outputs come straight from registers.
module imem_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT);
  localparam bit          TMO_EN    = (TIMEOUT != 0);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Running frame checksum: one byte folded into the XOR accumulator.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t             state_r, state_n;
  logic [7:0]         len_hi_r, len_hi_n;
  logic [15:0]        len_r, len_n;
  logic [7:0]         xor_r, xor_n;
  logic [1:0]         byte_idx_r, byte_idx_n;
  logic [23:0]        word_buf_r, word_buf_n;
  logic [15:0]        tmo_cnt_r, tmo_cnt_n;
  logic               mem_we_r, mem_we_n;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_n;
  logic [DATA_W-1:0]  mem_wdata_r, mem_wdata_n;
  logic [ADDR_W:0]    words_loaded_r, words_loaded_n;
  logic [1:0]         err_code_r, err_code_n;
  logic               rx_ready_r, rx_ready_n;
  logic               cpu_hold_r, cpu_hold_n;
  logic               load_done_r, load_done_n;
  logic               load_err_r, load_err_n;

  logic               accept_s;
  logic               in_rx_s;
  logic               tmo_hit_s;
  logic [15:0]        len_word_s;
  logic [ADDR_W:0]    words_next_s;

  // rx_ready is a registered decode of the receiving states, so it equals
  // "state is LEN_HI..CSUM" without a combinational path to the port.
  assign accept_s     = bus.rx_valid & rx_ready_r;
  assign in_rx_s      = rx_ready_r;
  assign tmo_hit_s    = TMO_EN && (tmo_cnt_r == (TMO_LIM - 16'd1));
  assign len_word_s   = {len_hi_r, bus.rx_data};
  assign words_next_s = words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state, datapath and output decode for the load FSM.
  always_comb begin
    state_n        = state_r;
    len_hi_n       = len_hi_r;
    len_n          = len_r;
    xor_n          = xor_r;
    byte_idx_n     = byte_idx_r;
    word_buf_n     = word_buf_r;
    mem_we_n       = 1'b0;
    mem_addr_n     = mem_addr_r;
    mem_wdata_n    = mem_wdata_r;
    words_loaded_n = words_loaded_r;
    err_code_n     = err_code_r;

    // Idle-cycle counter only runs while a frame is being received.
    if (in_rx_s) begin
      if (accept_s) begin
        tmo_cnt_n = 16'd0;
      end else begin
        tmo_cnt_n = tmo_cnt_r + 16'd1;
      end
    end else begin
      tmo_cnt_n = tmo_cnt_r;
    end

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_req) begin
          state_n        = S_LEN_HI;
          xor_n          = 8'd0;
          byte_idx_n     = 2'd0;
          words_loaded_n = '0;
          err_code_n     = ERR_NONE;
          tmo_cnt_n      = 16'd0;
        end else begin
          state_n = state_r;
        end
      end

      S_LEN_HI: begin
        if (accept_s) begin
          len_hi_n = bus.rx_data;
          xor_n    = csum_fold(xor_r, bus.rx_data);
          state_n  = S_LEN_LO;
        end else if (tmo_hit_s) begin
          state_n    = S_ERR;
          err_code_n = ERR_TMO;
        end else begin
          state_n = S_LEN_HI;
        end
      end

      S_LEN_LO: begin
        if (accept_s) begin
          len_n      = len_word_s;
          xor_n      = csum_fold(xor_r, bus.rx_data);
          byte_idx_n = 2'd0;
          if ((len_word_s == 16'd0) || ({1'b0, len_word_s} > MAX_WORDS)) begin
            state_n    = S_ERR;
            err_code_n = ERR_LEN;
          end else begin
            state_n = S_DATA;
          end
        end else if (tmo_hit_s) begin
          state_n    = S_ERR;
          err_code_n = ERR_TMO;
        end else begin
          state_n = S_LEN_LO;
        end
      end

      S_DATA: begin
        if (accept_s) begin
          xor_n      = csum_fold(xor_r, bus.rx_data);
          byte_idx_n = byte_idx_r + 2'd1;
          case (byte_idx_r)
            2'd0: word_buf_n[7:0]   = bus.rx_data;
            2'd1: word_buf_n[15:8]  = bus.rx_data;
            2'd2: word_buf_n[23:16] = bus.rx_data;
            2'd3: begin
              mem_wdata_n    = {bus.rx_data, word_buf_r};
              mem_we_n       = 1'b1;
              mem_addr_n     = words_loaded_r[ADDR_W-1:0];
              words_loaded_n = words_next_s;
            end
            default: word_buf_n = word_buf_r;
          endcase
          if ((byte_idx_r == 2'd3) && (16'(words_next_s) == len_r)) begin
            state_n = S_CSUM;
          end else begin
            state_n = S_DATA;
          end
        end else if (tmo_hit_s) begin
          state_n    = S_ERR;
          err_code_n = ERR_TMO;
        end else begin
          state_n = S_DATA;
        end
      end

      S_CSUM: begin
        if (accept_s) begin
          if (bus.rx_data == xor_r) begin
            state_n = S_DONE;
          end else begin
            state_n    = S_ERR;
            err_code_n = ERR_CSUM;
          end
        end else if (tmo_hit_s) begin
          state_n    = S_ERR;
          err_code_n = ERR_TMO;
        end else begin
          state_n = S_CSUM;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    rx_ready_n  = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                  (state_n == S_DATA)   || (state_n == S_CSUM);
    cpu_hold_n  = (state_n != S_DONE);
    load_done_n = (state_n == S_DONE);
    load_err_n  = (state_n == S_ERR);
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      len_hi_r       <= 8'd0;
      len_r          <= 16'd0;
      xor_r          <= 8'd0;
      byte_idx_r     <= 2'd0;
      word_buf_r     <= 24'd0;
      tmo_cnt_r      <= 16'd0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      words_loaded_r <= '0;
      err_code_r     <= ERR_NONE;
      rx_ready_r     <= 1'b0;
      cpu_hold_r     <= 1'b1;
      load_done_r    <= 1'b0;
      load_err_r     <= 1'b0;
    end else begin
      state_r        <= state_n;
      len_hi_r       <= len_hi_n;
      len_r          <= len_n;
      xor_r          <= xor_n;
      byte_idx_r     <= byte_idx_n;
      word_buf_r     <= word_buf_n;
      tmo_cnt_r      <= tmo_cnt_n;
      mem_we_r       <= mem_we_n;
      mem_addr_r     <= mem_addr_n;
      mem_wdata_r    <= mem_wdata_n;
      words_loaded_r <= words_loaded_n;
      err_code_r     <= err_code_n;
      rx_ready_r     <= rx_ready_n;
      cpu_hold_r     <= cpu_hold_n;
      load_done_r    <= load_done_n;
      load_err_r     <= load_err_n;
    end
  end

  assign bus.rx_ready  = rx_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign load_done     = load_done_r;
  assign load_err      = load_err_r;
  assign err_code      = err_code_r;
  assign words_loaded  = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as the
// stream is driven and matched against every mem_we pulse by a monitor.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;
  logic [9:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  imem_loader_if #(.DATA_W(32), .ADDR_W(9)) ifc ();

  imem_loader #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .bus          (ifc),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.mem_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write",
               ifc.mem_addr, ifc.mem_wdata);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ifc.mem_addr), 32'(e.addr));
        chk("wr_data", ifc.mem_wdata, e.data);
      end
    end
  end

  // Present one byte and return at the negedge following its acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    while (ifc.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("rx_ready_wait", 32'(ifc.rx_ready), 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic pulse_load;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] csum);
    exp_q.push_back('{addr: 9'd0, data: 32'h12345678});
    exp_q.push_back('{addr: 9'd1, data: 32'hDEADBEEF});
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(csum);
    ifc.rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    load_req     = 1'b0;
    ifc.rx_data  = 8'hA5;
    ifc.rx_valid = 1'b1;

    // 1. Reset with rx_valid high
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 32'(ifc.rx_ready), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(ifc.mem_addr), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rx_ready", 32'(ifc.rx_ready), 32'd0);
    ifc.rx_valid = 1'b0;

    // 2. Good two-word load
    pulse_load();
    chk("lenhi_rx_ready", 32'(ifc.rx_ready), 32'd1);
    send_good(8'h28);
    chk("good_done", 32'(load_done), 32'd1);
    chk("good_hold", 32'(cpu_hold), 32'd0);
    chk("good_words", 32'(words_loaded), 32'd2);
    chk("good_err_code", 32'(err_code), 32'd0);
    chk("good_rx_ready", 32'(ifc.rx_ready), 32'd0);
    chk("good_q_empty", 32'(exp_q.size()), 32'd0);

    // 3. Bad checksum: writes still happen, then error
    pulse_load();
    chk("reload_done_clr", 32'(load_done), 32'd0);
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    send_good(8'h29);
    chk("csum_err", 32'(load_err), 32'd1);
    chk("csum_code", 32'(err_code), 32'd2);
    chk("csum_hold", 32'(cpu_hold), 32'd1);
    chk("csum_words", 32'(words_loaded), 32'd2);
    chk("csum_q_empty", 32'(exp_q.size()), 32'd0);

    // 4. Length boundaries: 0 and 513 words
    pulse_load();
    send_byte(8'h00); send_byte(8'h00);
    ifc.rx_valid = 1'b0;
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_code", 32'(err_code), 32'd1);
    chk("len0_words", 32'(words_loaded), 32'd0);
    pulse_load();
    send_byte(8'h02); send_byte(8'h01);
    ifc.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("len513_err", 32'(load_err), 32'd1);
    chk("len513_code", 32'(err_code), 32'd1);
    chk("len513_hold", 32'(cpu_hold), 32'd1);

    // 5. Idle timeout 16 cycles after the last accepted byte
    pulse_load();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h78); send_byte(8'h56);
    ifc.rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_15_err", 32'(load_err), 32'd0);
    chk("tmo_15_ready", 32'(ifc.rx_ready), 32'd1);
    @(negedge clk);
    chk("tmo_16_err", 32'(load_err), 32'd1);
    chk("tmo_16_code", 32'(err_code), 32'd3);
    chk("tmo_words", 32'(words_loaded), 32'd0);

    // 6. Back-to-back words, ignored load_req, reset mid-word 2
    pulse_load();
    exp_q.push_back('{addr: 9'd0, data: 32'h44332211});
    exp_q.push_back('{addr: 9'd1, data: 32'h88776655});
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("b2b_words1", 32'(words_loaded), 32'd1);
    load_req = 1'b1;
    send_byte(8'h55);
    load_req = 1'b0;
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    chk("b2b_words2", 32'(words_loaded), 32'd2);
    chk("b2b_not_done", 32'(load_done), 32'd0);
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ifc.rx_valid = 1'b0;
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_ready", 32'(ifc.rx_ready), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    pulse_load();
    send_good(8'h28);
    chk("after_rst_done", 32'(load_done), 32'd1);
    chk("after_rst_hold", 32'(cpu_hold), 32'd0);
    chk("after_rst_words", 32'(words_loaded), 32'd2);
    chk("after_rst_q_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
